decoder_nx2n_seq: RTL and testbench

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with enable, valid/ready input handshake and an optional self-timed scan mode. It is the next-generation decoder for the combinational library and serves as a synchronous select generator for row/column drive, chip-select fan-out and bank enables. Direct mode decodes a handshaked select. Scan mode walks the one-hot output across all lines, advancing one line every DWELL cycles.

---
 rtl/decoder_pkg.sv | 18 +
 rtl/decoder_nx2n_comb.sv | 17 +
 rtl/decoder_nx2n_seq.sv | 129 ++++++++++++
 tb/tb_decoder_nx2n_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder family.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } dec_state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Dwell counter needs at least one bit even when DWELL is 1.
    function automatic int dwell_cnt_w(input int dwell);
        return (dwell <= 2) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/decoder_nx2n_comb.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder with an enable gate.
module decoder_nx2n_comb #(
    parameter int SEL_W = 3
) (
    input  logic                    en,
    input  logic [SEL_W-1:0]        sel,
    output logic [(2**SEL_W)-1:0]   q
);

    always_comb begin
        q = '0;
        if (en) begin
            q[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_nx2n_seq.sv
// Registered one-hot decoder with valid/ready select input and optional scan mode.
// Scan mode is compiled in only when DECODER_SCAN_EN is defined.
//
// state | meaning
// IDLE  | q all-zero, q_valid low, addr and dwell count cleared
// HOLD  | q = onehot(addr) from the last accepted sel, static
// SCAN  | q = onehot(addr), addr advances every DWELL cycles
module decoder_nx2n_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [(2**SEL_W)-1:0]   q,
    output logic                    q_valid,
    output logic [SEL_W-1:0]        addr,
    output logic                    wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam int CNT_W = dwell_cnt_w(DWELL);

    dec_state_e         state, state_next;
    logic [SEL_W-1:0]   addr_r, addr_next;
    logic [OUT_W-1:0]   q_r, q_next;
    logic               q_valid_r;
    logic               wrap_r, wrap_next;
    logic               mode_eff;
    logic               transfer;

`ifdef DECODER_SCAN_EN
    logic [CNT_W-1:0]   cnt, cnt_next;

    assign mode_eff = mode;
`else
    logic               unused_mode;

    assign unused_mode = mode;
    assign mode_eff    = MODE_DIRECT;
`endif

    assign in_ready = en & ~mode_eff;
    assign transfer = in_valid & in_ready;

    always_comb begin
        state_next = state;
        addr_next  = addr_r;
        wrap_next  = 1'b0;
`ifdef DECODER_SCAN_EN
        cnt_next   = cnt;
`endif
        if (!en) begin
            state_next = IDLE;
            addr_next  = '0;
`ifdef DECODER_SCAN_EN
            cnt_next   = '0;
`endif
        end else if (transfer) begin
            // sel only reaches the datapath here, so X on an idle bus stays out.
            state_next = HOLD;
            addr_next  = sel;
`ifdef DECODER_SCAN_EN
            cnt_next   = '0;
`endif
        end
`ifdef DECODER_SCAN_EN
        else if (mode_eff && state != SCAN) begin
            state_next = SCAN;
            addr_next  = '0;
            cnt_next   = '0;
        end else if (!mode_eff && state == SCAN) begin
            state_next = IDLE;
            addr_next  = '0;
            cnt_next   = '0;
        end else if (state == SCAN) begin
            if (cnt == CNT_W'(DWELL - 1)) begin
                cnt_next  = '0;
                addr_next = addr_r + SEL_W'(1);
                wrap_next = &addr_r;
            end else begin
                cnt_next  = cnt + CNT_W'(1);
            end
        end
`endif
    end

    decoder_nx2n_comb #(
        .SEL_W (SEL_W)
    ) u_comb (
        .en  (state_next != IDLE),
        .sel (addr_next),
        .q   (q_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_r    <= '0;
            q_r       <= '0;
            q_valid_r <= 1'b0;
            wrap_r    <= 1'b0;
`ifdef DECODER_SCAN_EN
            cnt       <= '0;
`endif
        end else begin
            state     <= state_next;
            addr_r    <= addr_next;
            q_r       <= q_next;
            q_valid_r <= (state_next != IDLE);
            wrap_r    <= wrap_next;
`ifdef DECODER_SCAN_EN
            cnt       <= cnt_next;
`endif
        end
    end

    assign q       = q_r;
    assign q_valid = q_valid_r;
    assign addr    = addr_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Self-checking bench for decoder_nx2n_seq against a time-based behavioural model.
module tb_decoder_nx2n_seq;

    localparam int SEL_W = 3;
    localparam int DWELL = 2;
    localparam int OUT_W = 8;
`ifdef DECODER_SCAN_EN
    localparam bit SCAN_ON = 1'b1;
`else
    localparam bit SCAN_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               mode;
    logic               in_valid;
    logic [SEL_W-1:0]   sel;
    logic               in_ready;
    logic [OUT_W-1:0]   q;
    logic               q_valid;
    logic [SEL_W-1:0]   addr;
    logic               wrap;

    decoder_nx2n_seq #(
        .SEL_W (SEL_W),
        .DWELL (DWELL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .q        (q),
        .q_valid  (q_valid),
        .addr     (addr),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: active flag, decoded index, and time since scan entry.
    bit m_valid;
    bit m_scan;
    bit m_wrap;
    int m_addr;
    int m_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit me;
        me     = SCAN_ON && mode;
        m_wrap = 1'b0;
        if (!rst_n || !en) begin
            m_valid = 1'b0;
            m_addr  = 0;
            m_scan  = 1'b0;
        end else if (in_valid && !me) begin
            m_valid = 1'b1;
            m_addr  = int'(sel);
            m_scan  = 1'b0;
        end else if (me) begin
            if (!m_scan) begin
                m_scan = 1'b1;
                m_t    = 0;
            end else begin
                m_t++;
            end
            m_valid = 1'b1;
            m_addr  = (m_t / DWELL) % OUT_W;
            m_wrap  = (m_t > 0) && (m_t % (OUT_W * DWELL) == 0);
        end else if (m_scan) begin
            m_valid = 1'b0;
            m_addr  = 0;
            m_scan  = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_q;
        exp_q = m_valid ? (32'd1 << m_addr) : 32'd0;
        chk("q", 32'(q), exp_q);
        chk("q_valid", 32'(q_valid), 32'(m_valid));
        chk("addr", 32'(addr), 32'(m_addr));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("in_ready", 32'(in_ready), 32'(en & ~(SCAN_ON & mode)));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int wraps;
        m_valid  = 1'b0;
        m_scan   = 1'b0;
        m_wrap   = 1'b0;
        m_addr   = 0;
        m_t      = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        mode     = 1'b0;
        in_valid = 1'b1;
        sel      = 3'd7;
        @(negedge clk);
        repeat (2) cyc();
        chk("rst_q", 32'(q), 32'h0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        cyc();
        chk("rst_rel_qv", 32'(q_valid), 32'h0);

        // Direct decode, hold, back-to-back transfers.
        sel      = 3'd5;
        in_valid = 1'b1;
        cyc();
        chk("dir_q5", 32'(q), 32'h20);
        in_valid = 1'b0;
        sel      = 3'd1;
        repeat (3) cyc();
        chk("dir_hold", 32'(q), 32'h20);
        in_valid = 1'b1;
        sel      = 3'd0;
        cyc();
        chk("b2b_0", 32'(q), 32'h01);
        sel      = 3'd7;
        cyc();
        chk("b2b_7", 32'(q), 32'h80);
        in_valid = 1'b0;

        for (int i = 0; i < 80; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            in_valid = 1'($urandom_range(0, 1));
            sel      = SEL_W'($urandom);
            mode     = SCAN_ON ? 1'b0 : 1'($urandom_range(0, 1));
            cyc();
        end

`ifdef DECODER_SCAN_EN
        en       = 1'b1;
        in_valid = 1'b0;
        mode     = 1'b0;
        cyc();
        mode  = 1'b1;
        wraps = 0;
        for (int i = 0; i < OUT_W * DWELL * 2 + 1; i++) begin
            cyc();
            wraps += int'(wrap);
        end
        chk("wrap_count", 32'(wraps), 32'd2);

        for (int i = 0; i < 40 && m_addr != 3; i++) cyc();
        en = 1'b0;
        cyc();
        chk("en_low_q", 32'(q), 32'h0);
        en = 1'b1;
        cyc();
        chk("reen_q0", 32'(q), 32'h01);
        cyc();
        chk("reen_dwell", 32'(q), 32'h01);
        cyc();
        chk("reen_q1", 32'(q), 32'h02);

        mode     = 1'b0;
        in_valid = 1'b1;
        sel      = 3'd2;
        cyc();
        chk("fall_xfer_q", 32'(q), 32'h04);
        in_valid = 1'b0;
        mode     = 1'b1;
        repeat (3) cyc();
        mode = 1'b0;
        cyc();
        chk("fall_idle_q", 32'(q), 32'h0);
        chk("fall_idle_qv", 32'(q_valid), 32'h0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            en       = ($urandom_range(0, 14) != 0);
            in_valid = 1'($urandom_range(0, 1));
            sel      = SEL_W'($urandom);
            cyc();
        end
`else
        en       = 1'b1;
        mode     = 1'b1;
        in_valid = 1'b1;
        sel      = 3'd6;
        #1;
        chk("noscan_ready", 32'(in_ready), 32'h1);
        cyc();
        chk("noscan_q", 32'(q), 32'h40);
        wraps = 0;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            sel      = SEL_W'($urandom);
            cyc();
            wraps += int'(wrap);
        end
        chk("noscan_wrap", 32'(wraps), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
